// File: rtl/ttl_74191_mod_pkg.sv
// rtl/ttl_74191_mod_pkg.sv - parameter legality helper for the presettable up/down counter
package ttl_74191_mod_pkg;

  function automatic bit modulus_ok(input int width, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/ttl_74191_mod.sv
// rtl/ttl_74191_mod.sv - 74191-style presettable up/down counter with programmable modulus and async clear
module ttl_74191_mod
  import ttl_74191_mod_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 16,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Load_bar,
  input  logic             Enable_bar,
  input  logic             Down_Up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Max_Min,
  output logic             RCO_bar
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count;
  logic             max_min_i;
  logic             rco_bar_i;

  generate
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("ttl_74191_mod: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  // Out-of-range loaded values fall back into range: up wraps to 0, down decrements normally.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      count <= '0;
    end else if (!Load_bar) begin
      count <= D;
    end else if (!Enable_bar) begin
      if (!Down_Up) begin
        count <= (count >= TOP) ? '0 : count + 1'b1;
      end else begin
        count <= (count == '0) ? TOP : count - 1'b1;
      end
    end
  end

  assign max_min_i = Down_Up ? (count == '0) : (count == TOP);
  // Low only in the Clk-low phase so the rising edge lines up with the next Clk rise.
  assign rco_bar_i = ~(max_min_i & ~Enable_bar & ~Clk);

  generate
    if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodelay
      assign Q       = count;
      assign Max_Min = max_min_i;
      assign RCO_bar = rco_bar_i;
    end else begin : g_delay
      assign #(DELAY_RISE, DELAY_FALL) Q       = count;
      assign #(DELAY_RISE, DELAY_FALL) Max_Min = max_min_i;
      assign #(DELAY_RISE, DELAY_FALL) RCO_bar = rco_bar_i;
    end
  endgenerate

endmodule

// File: tb/tb_ttl_74191_mod.sv
// tb/tb_ttl_74191_mod.sv - self-checking bench for ttl_74191_mod (decade instance plus two-stage cascade)
module tb_ttl_74191_mod;

  localparam int MOD = 10;

  int n_pass = 0;
  int n_total = 0;

  logic       clk = 1'b0;
  logic       clr, ld_n, en_n, dn;
  logic [3:0] d;
  logic [3:0] q;
  logic       mm, rco;

  logic       c_clr, c_ld, c_en_n;
  logic [3:0] lo_q, hi_q;
  logic       lo_mm, lo_rco, hi_mm, hi_rco;

  always #5 clk = ~clk;

  ttl_74191_mod #(.WIDTH(4), .MODULUS(MOD)) dut (
    .Clk(clk), .Clear(clr), .Load_bar(ld_n), .Enable_bar(en_n), .Down_Up(dn),
    .D(d), .Q(q), .Max_Min(mm), .RCO_bar(rco)
  );

  ttl_74191_mod #(.WIDTH(4), .MODULUS(16)) u_lo (
    .Clk(clk), .Clear(c_clr), .Load_bar(c_ld), .Enable_bar(c_en_n), .Down_Up(1'b0),
    .D(4'hF), .Q(lo_q), .Max_Min(lo_mm), .RCO_bar(lo_rco)
  );

  ttl_74191_mod #(.WIDTH(4), .MODULUS(16)) u_hi (
    .Clk(lo_rco), .Clear(c_clr), .Load_bar(1'b1), .Enable_bar(1'b0), .Down_Up(1'b0),
    .D(4'h0), .Q(hi_q), .Max_Min(hi_mm), .RCO_bar(hi_rco)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model of the decade instance, written from the counting rules.
  int m_q;
  always @(posedge clk or posedge clr) begin
    if (clr) m_q <= 0;
    else if (!ld_n) m_q <= int'(d);
    else if (!en_n) begin
      if (!dn) m_q <= (m_q < MOD - 1) ? m_q + 1 : 0;
      else m_q <= (m_q == 0) ? MOD - 1 : m_q - 1;
    end
  end

  function automatic int model_mm(input int value, input logic down);
    return down ? int'(value == 0) : int'(value == MOD - 1);
  endfunction

  task automatic compare_model(input logic clk_level);
    int exp_mm, exp_rco;
    exp_mm  = model_mm(m_q, dn);
    exp_rco = (exp_mm == 1 && !en_n && !clk_level) ? 0 : 1;
    check("model_q", int'(q), m_q);
    check("model_max_min", int'(mm), exp_mm);
    check("model_rco_bar", int'(rco), exp_rco);
  endtask

  always @(posedge clk) begin
    #1;
    compare_model(1'b1);
  end

  always @(negedge clk) begin
    #1;
    compare_model(1'b0);
  end

  task automatic edge_then(input int settle);
    @(posedge clk);
    #settle;
  endtask

  int up_seq[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_seq[4]   = '{1, 0, 9, 8};

  initial begin
    clr = 1'b1; ld_n = 1'b1; en_n = 1'b1; dn = 1'b0; d = 4'd0;
    c_clr = 1'b1; c_ld = 1'b1; c_en_n = 1'b1;

    // Reset state
    #2;
    check("reset_q", int'(q), 0);
    check("reset_max_min_up", int'(mm), 0);
    dn = 1'b1; en_n = 1'b0;
    #1;
    check("reset_max_min_down", int'(mm), 1);
    check("reset_rco_clk_low", int'(rco), 0);
    @(negedge clk);
    clr = 1'b0; dn = 1'b0; en_n = 1'b0;

    // Decade up-wrap
    for (int i = 0; i < 12; i++) begin
      edge_then(2);
      check("up_wrap_q", int'(q), up_seq[i]);
      @(negedge clk);
      #2;
      check("up_wrap_rco", int'(rco), (up_seq[i] == 9) ? 0 : 1);
    end

    // Asynchronous clear mid-count at Q=9, held across edges
    ld_n = 1'b0; d = 4'd9;
    edge_then(2);
    check("load_9", int'(q), 9);
    @(negedge clk);
    ld_n = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    check("async_clear_q", int'(q), 0);
    for (int i = 0; i < 3; i++) begin
      edge_then(2);
      check("clear_held_q", int'(q), 0);
    end
    @(negedge clk);
    clr = 1'b0;

    // Down-wrap
    ld_n = 1'b0; d = 4'd2;
    edge_then(2);
    check("load_2", int'(q), 2);
    @(negedge clk);
    ld_n = 1'b1; dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_then(2);
      check("down_wrap_q", int'(q), dn_seq[i]);
    end
    @(negedge clk);
    ld_n = 1'b0; d = 4'd0; en_n = 1'b1;
    edge_then(2);
    @(negedge clk);
    ld_n = 1'b1;
    #2;
    check("min_flag_down", int'(mm), 1);
    dn = 1'b0;
    #1;
    check("min_flag_dir_toggle", int'(mm), 0);

    // Load priority and out-of-range values
    @(negedge clk);
    ld_n = 1'b0; en_n = 1'b0; d = 4'd13;
    edge_then(2);
    check("load_13", int'(q), 13);
    @(negedge clk);
    ld_n = 1'b1;
    edge_then(2);
    check("oor_up_wraps", int'(q), 0);
    @(negedge clk);
    ld_n = 1'b0;
    edge_then(2);
    @(negedge clk);
    ld_n = 1'b1; dn = 1'b1;
    edge_then(2);
    check("oor_down_dec", int'(q), 12);

    // Clear asserted 1 ns before an edge that would load
    @(negedge clk);
    ld_n = 1'b0; d = 4'd7; en_n = 1'b1;
    #4;
    clr = 1'b1;
    edge_then(2);
    check("clear_beats_load", int'(q), 0);
    @(negedge clk);
    clr = 1'b0;
    edge_then(2);
    check("load_after_clear", int'(q), 7);
    @(negedge clk);
    ld_n = 1'b1;

    // Hold and cascade
    c_clr = 1'b0; c_ld = 1'b0;
    edge_then(2);
    @(negedge clk);
    c_ld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      edge_then(2);
      check("cascade_hold_lo", int'(lo_q), 15);
      check("cascade_hold_hi", int'(hi_q), 0);
      @(negedge clk);
      #1;
      check("cascade_hold_rco", int'(lo_rco), 1);
    end
    c_en_n = 1'b0;
    #1;
    check("cascade_rco_low", int'(lo_rco), 0);
    edge_then(1);
    check("cascade_lo_wrap", int'(lo_q), 0);
    check("cascade_hi_inc", int'(hi_q), 1);
    check("cascade_hi_rco", int'(hi_rco), 1);
    @(negedge clk);
    c_en_n = 1'b1;
    #2;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
